sv32_bht: RTL and testbench

SV32_BHT -- requirements
Module: sv32_bht

---
 rtl/ariane_pkg.sv | 23 ++
 rtl/config_pkg.sv | 12 +
 rtl/bht_sat_ctr.sv | 20 ++
 rtl/sv32_bht.sv | 89 ++++++++
 tb/tb_sv32_bht.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Shared BHT types and the PC-to-index helper.
package ariane_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    // Compressed ISA allows halfword-aligned branches, so the index starts at bit 1.
    function automatic logic [31:0] bht_index(input logic [63:0] pc,
                                              input logic        rvc,
                                              input int unsigned idx_w);
        logic [63:0] shifted;
        shifted = rvc ? (pc >> 1) : (pc >> 2);
        return 32'(shifted) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration record shared by the branch-prediction blocks.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        bit          RVC;
        int unsigned BHTEntries;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, RVC: 1'b1, BHTEntries: 128};

endpackage

// File: rtl/bht_sat_ctr.sv
// Next value of a 2-bit saturating direction counter, including first allocation.
module bht_sat_ctr (
    input  logic       i_valid,
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_c
);

    always_comb begin
        o_ctr_c = i_ctr;
        if (!i_valid) begin
            o_ctr_c = i_taken ? 2'd2 : 2'd1;
        end else if (i_taken) begin
            if (i_ctr != 2'd3) o_ctr_c = i_ctr + 2'd1;
        end else begin
            if (i_ctr != 2'd0) o_ctr_c = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/sv32_bht.sv
// Branch history table: flop-based 2-bit counters with a one-entry-per-cycle flush sweep.
module sv32_bht
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NR_ENTRIES = CVA6Cfg.BHTEntries
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_bp_i,
    input  logic                    debug_mode_i,
    input  logic [CVA6Cfg.XLEN-1:0] vpc_i,
    input  logic                    upd_valid_i,
    input  logic [CVA6Cfg.XLEN-1:0] upd_pc_i,
    input  logic                    upd_taken_i,
    output logic                    pred_valid_o,
    output logic                    pred_taken_o,
    output logic                    busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    bht_state_e       r_state;
    bht_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_sweep;
    bht_entry_t       r_table [NR_ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    bht_entry_t       w_rd;
    bht_entry_t       w_upd_old;
    logic [1:0]       w_upd_ctr;
    logic             w_upd_en;

    assign w_rd_idx  = IDX_W'(bht_index(64'(vpc_i), CVA6Cfg.RVC, IDX_W));
    assign w_upd_idx = IDX_W'(bht_index(64'(upd_pc_i), CVA6Cfg.RVC, IDX_W));
    assign w_rd      = r_table[w_rd_idx];
    assign w_upd_old = r_table[w_upd_idx];
    assign w_upd_en  = upd_valid_i && !debug_mode_i && !flush_bp_i && (r_state == IDLE);

    bht_sat_ctr u_sat_ctr (
        .i_valid (w_upd_old.valid),
        .i_ctr   (w_upd_old.ctr),
        .i_taken (upd_taken_i),
        .o_ctr_c (w_upd_ctr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Last sweep index exits FLUSH unless a new flush request restarts the sweep.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (flush_bp_i) w_state_nxt = FLUSH;
            FLUSH:   if (!flush_bp_i && (r_sweep == IDX_W'(NR_ENTRIES - 1))) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        pred_valid_o = 1'b0;
        pred_taken_o = 1'b0;
        busy_o       = (r_state == FLUSH);
        pred_valid_o = w_rd.valid && (r_state == IDLE);
        pred_taken_o = w_rd.ctr[1] && pred_valid_o;
    end

    // Natural wrap of the counter lines up with the FLUSH exit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                           r_sweep <= '0;
        else if (r_state == IDLE || flush_bp_i) r_sweep <= '0;
        else                                   r_sweep <= r_sweep + IDX_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) r_table[i] <= '0;
        end else if (r_state == FLUSH) begin
            r_table[r_sweep] <= '0;
        end else if (w_upd_en) begin
            r_table[w_upd_idx] <= '{valid: 1'b1, ctr: w_upd_ctr};
        end
    end

endmodule

// File: tb/tb_sv32_bht.sv
// Scoreboard bench for sv32_bht: directed updates, saturation, flush sweeps and reset.
module tb_sv32_bht;

    logic        clk;
    logic        rst_ni;
    logic        flush_bp_i;
    logic        debug_mode_i;
    logic [31:0] vpc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q [$];

    sv32_bht u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_bp_i   (flush_bp_i),
        .debug_mode_i (debug_mode_i),
        .vpc_i        (vpc_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .pred_valid_o (pred_valid_o),
        .pred_taken_o (pred_taken_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {valid,taken} is queued when the PC is driven, compared once outputs settle.
    task automatic lookup(input string tag, input logic [31:0] pc, input logic v, input logic t);
        logic [1:0] e;
        vpc_i = pc;
        exp_q.push_back({v, t});
        #1;
        e = exp_q.pop_front();
        check(tag, 32'({pred_valid_o, pred_taken_o}), 32'(e));
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic dbg);
        @(negedge clk);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        debug_mode_i = dbg;
        @(negedge clk);
        upd_valid_i  = 1'b0;
        debug_mode_i = 1'b0;
    endtask

    // Counts busy cycles after a flush pulse; optionally re-flushes at a given sample.
    task automatic run_sweep(input int restart_at, output int n);
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (!busy_o) break;
            n++;
            check("sweep_pred_valid", 32'(pred_valid_o), 32'd0);
            if (n == 10) begin
                upd_valid_i = 1'b1;
                upd_pc_i    = 32'h8000_0004;
                upd_taken_i = 1'b1;
            end
            if (n == restart_at) flush_bp_i = 1'b1;
            @(negedge clk);
            flush_bp_i  = 1'b0;
            upd_valid_i = 1'b0;
        end
    endtask

    task automatic pulse_flush(input logic with_upd);
        @(negedge clk);
        flush_bp_i  = 1'b1;
        upd_valid_i = with_upd;
        upd_pc_i    = 32'h8000_0040;
        upd_taken_i = 1'b1;
        @(negedge clk);
        flush_bp_i  = 1'b0;
        upd_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_ni       = 1'b0;
        flush_bp_i   = 1'b0;
        debug_mode_i = 1'b0;
        vpc_i        = '0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;

        repeat (3) @(negedge clk);
        lookup("reset_lookup", 32'h8000_0000, 1'b0, 1'b0);
        check("reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        lookup("post_reset_lookup", 32'h8000_0000, 1'b0, 1'b0);

        // Same-cycle lookup of the index being written returns the old entry.
        @(negedge clk);
        upd_valid_i = 1'b1;
        upd_pc_i    = 32'h8000_0010;
        upd_taken_i = 1'b1;
        lookup("same_cycle_old", 32'h8000_0010, 1'b0, 1'b0);
        @(negedge clk);
        upd_valid_i = 1'b0;
        lookup("alloc_taken", 32'h8000_0010, 1'b1, 1'b1);
        lookup("alias_pc_bit8", 32'h8000_0110, 1'b1, 1'b1);

        upd(32'h8000_0010, 1'b0, 1'b0);
        lookup("nt1_ctr1", 32'h8000_0010, 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b0, 1'b0);
        lookup("nt2_ctr0", 32'h8000_0010, 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b0, 1'b0);
        lookup("nt3_sat0", 32'h8000_0010, 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b1, 1'b0);
        lookup("from0_tk_ctr1", 32'h8000_0010, 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b1, 1'b0);
        lookup("from1_tk_ctr2", 32'h8000_0010, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) upd(32'h8000_0010, 1'b1, 1'b0);
        lookup("tk5_sat3", 32'h8000_0010, 1'b1, 1'b1);
        upd(32'h8000_0010, 1'b0, 1'b0);
        lookup("sat3_nt_ctr2", 32'h8000_0010, 1'b1, 1'b1);
        upd(32'h8000_0010, 1'b0, 1'b0);
        lookup("ctr2_nt_ctr1", 32'h8000_0010, 1'b1, 1'b0);

        upd(32'h8000_0020, 1'b0, 1'b0);
        lookup("alloc_not_taken", 32'h8000_0020, 1'b1, 1'b0);
        upd(32'h8000_0020, 1'b1, 1'b0);
        lookup("alloc1_tk_ctr2", 32'h8000_0020, 1'b1, 1'b1);

        upd(32'h8000_0002, 1'b1, 1'b0);
        lookup("rvc_idx_02", 32'h8000_0002, 1'b1, 1'b1);
        lookup("rvc_idx_04_distinct", 32'h8000_0004, 1'b0, 1'b0);

        upd(32'h8000_0004, 1'b1, 1'b1);
        lookup("debug_no_alloc", 32'h8000_0004, 1'b0, 1'b0);
        upd(32'h8000_0002, 1'b0, 1'b1);
        lookup("debug_no_change", 32'h8000_0002, 1'b1, 1'b1);

        upd(32'h8000_00F0, 1'b1, 1'b0);
        lookup("pre_flush_f0", 32'h8000_00F0, 1'b1, 1'b1);

        vpc_i = 32'h8000_00F0;
        pulse_flush(1'b1);
        run_sweep(0, n);
        check("flush_busy_len", 32'(n), 32'd128);
        check("flush_busy_clear", 32'(busy_o), 32'd0);
        lookup("flushed_10", 32'h8000_0010, 1'b0, 1'b0);
        lookup("flushed_02", 32'h8000_0002, 1'b0, 1'b0);
        lookup("flushed_20", 32'h8000_0020, 1'b0, 1'b0);
        lookup("flushed_f0", 32'h8000_00F0, 1'b0, 1'b0);
        lookup("flush_dropped_upd", 32'h8000_0040, 1'b0, 1'b0);
        lookup("sweep_dropped_upd", 32'h8000_0004, 1'b0, 1'b0);

        upd(32'h8000_0010, 1'b1, 1'b0);
        lookup("refill_10", 32'h8000_0010, 1'b1, 1'b1);
        pulse_flush(1'b0);
        run_sweep(51, n);
        check("restart_busy_len", 32'(n), 32'd179);
        lookup("restart_flushed_10", 32'h8000_0010, 1'b0, 1'b0);

        upd(32'h8000_00F0, 1'b1, 1'b0);
        lookup("refill_f0", 32'h8000_00F0, 1'b1, 1'b1);
        pulse_flush(1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_flush_rst_busy", 32'(busy_o), 32'd0);
        lookup("mid_flush_rst_pred", 32'h8000_00F0, 1'b0, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("after_rst_busy", 32'(busy_o), 32'd0);
        lookup("after_rst_f0", 32'h8000_00F0, 1'b0, 1'b0);
        upd(32'h8000_0010, 1'b1, 1'b0);
        lookup("after_rst_update", 32'h8000_0010, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
